// File: rtl/scoreboard_param.sv
// Register scoreboard for the in-order issue stage. For each architectural
// register it tracks whether a write is pending, which functional unit owns
// it, and how many cycles remain until writeback. It detects RAW and WAW
// hazards for the instruction being issued and supports per-FU flush.
module scoreboard_param #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_FU   = 4,
    parameter int FU_W     = 2,
    parameter int LAT_W    = 4,
    parameter int ZERO_REG = 1,
    parameter int FORWARD  = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                issue_valid,
    input  logic [ADDR_W-1:0]   issue_rd,
    input  logic                issue_rd_we,
    input  logic [ADDR_W-1:0]   issue_rs1,
    input  logic [ADDR_W-1:0]   issue_rs2,
    input  logic [FU_W-1:0]     issue_fu,
    input  logic [LAT_W-1:0]    issue_lat,
    output logic                issue_ready,
    input  logic                flush_valid,
    input  logic [NUM_FU-1:0]   flush_fu_mask,
    output logic [NUM_REGS-1:0] pnd_vec,
    output logic [FU_W-1:0]     rs1_fu,
    output logic [FU_W-1:0]     rs2_fu,
    output logic [ADDR_W:0]     pending_count
);

    // Address and FU-id spaces may be larger than the populated tables, so
    // lookups go through zero-padded views to keep every index in range.
    localparam int REG_SPACE = 1 << ADDR_W;
    localparam int FU_SPACE  = 1 << FU_W;

    logic [NUM_REGS-1:0] pend_q;
    logic [NUM_REGS-1:0] pend_d;
    logic [FU_W-1:0]     fu_q  [NUM_REGS];
    logic [FU_W-1:0]     fu_d  [NUM_REGS];
    logic [LAT_W-1:0]    cnt_q [NUM_REGS];
    logic [LAT_W-1:0]    cnt_d [NUM_REGS];
    logic [ADDR_W:0]     pendingCount_q;
    logic [ADDR_W:0]     pendingCount_d;

    logic [REG_SPACE-1:0] busyFull;
    logic [FU_W-1:0]      fuFull [REG_SPACE];
    logic [FU_SPACE-1:0]  maskFull;
    logic [LAT_W-1:0]     issueLatClamped;
    logic                 hazard;
    logic                 accept;

    // A register is busy while pending, except in its last cycle when forwarding covers it.
    always_comb begin
        busyFull = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            busyFull[r] = pend_q[r] && !((FORWARD != 0) && (cnt_q[r] == LAT_W'(1)));
        end
        if (ZERO_REG != 0) begin
            busyFull[0] = 1'b0;
        end
    end

    // Owner lookup for the two source operands.
    always_comb begin
        for (int i = 0; i < REG_SPACE; i++) begin
            fuFull[i] = '0;
        end
        for (int r = 0; r < NUM_REGS; r++) begin
            fuFull[r] = fu_q[r];
        end
        rs1_fu = fuFull[issue_rs1];
        rs2_fu = fuFull[issue_rs2];
    end

    // Hazard detection and issue handshake; a flush cycle never accepts an issue.
    always_comb begin
        hazard          = busyFull[issue_rs1] || busyFull[issue_rs2] ||
                          (issue_rd_we && busyFull[issue_rd]);
        issue_ready     = !hazard && !flush_valid;
        accept          = issue_valid && issue_ready;
        issueLatClamped = (issue_lat == '0) ? LAT_W'(1) : issue_lat;
        maskFull                = '0;
        maskFull[NUM_FU-1:0]    = flush_fu_mask;
    end

    // Next-state per entry: countdown, then flush, then issue write (highest priority).
    always_comb begin
        pendingCount_d = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            pend_d[r] = pend_q[r];
            fu_d[r]   = fu_q[r];
            cnt_d[r]  = cnt_q[r];
            if (pend_q[r] && (cnt_q[r] != '0)) begin
                cnt_d[r] = cnt_q[r] - LAT_W'(1);
                if (cnt_q[r] == LAT_W'(1)) begin
                    pend_d[r] = 1'b0;
                end
            end
            if (flush_valid && pend_q[r] && maskFull[fu_q[r]]) begin
                pend_d[r] = 1'b0;
                cnt_d[r]  = '0;
            end
            if (accept && issue_rd_we && (issue_rd == ADDR_W'(r)) &&
                !((ZERO_REG != 0) && (r == 0))) begin
                pend_d[r] = 1'b1;
                fu_d[r]   = issue_fu;
                cnt_d[r]  = issueLatClamped;
            end
            pendingCount_d = pendingCount_d + (ADDR_W+1)'(pend_d[r]);
        end
    end

    // Scoreboard state registers, cleared asynchronously by an active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_q         <= '0;
            pendingCount_q <= '0;
            for (int r = 0; r < NUM_REGS; r++) begin
                fu_q[r]  <= '0;
                cnt_q[r] <= '0;
            end
        end else begin
            pend_q         <= pend_d;
            pendingCount_q <= pendingCount_d;
            for (int r = 0; r < NUM_REGS; r++) begin
                fu_q[r]  <= fu_d[r];
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

    assign pnd_vec       = pend_q;
    assign pending_count = pendingCount_q;

endmodule

// File: tb/tb_scoreboard_param.sv
// Testbench for scoreboard_param. Two instances share one input stream:
// A with ZERO_REG=1/FORWARD=1, B with ZERO_REG=0/FORWARD=0. A reference
// model keeps, per register, the absolute cycle at which the pending write
// completes and checks every output of both instances each cycle.
module tb_scoreboard_param;

    localparam int NR = 32;
    localparam int AW = 5;
    localparam int NF = 4;
    localparam int FW = 2;
    localparam int LW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          issueValid = 1'b0;
    logic [AW-1:0] issueRd = '0;
    logic          issueRdWe = 1'b0;
    logic [AW-1:0] issueRs1 = '0;
    logic [AW-1:0] issueRs2 = '0;
    logic [FW-1:0] issueFu = '0;
    logic [LW-1:0] issueLat = '0;
    logic          flushValid = 1'b0;
    logic [NF-1:0] flushMask = '0;

    logic          readyA, readyB;
    logic [NR-1:0] pndA, pndB;
    logic [FW-1:0] rs1FuA, rs2FuA, rs1FuB, rs2FuB;
    logic [AW:0]   countA, countB;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int wb  [2][NR];
    int own [2][NR];

    scoreboard_param #(.ZERO_REG(1), .FORWARD(1)) dutA (
        .clk(clk), .reset(reset), .issue_valid(issueValid), .issue_rd(issueRd),
        .issue_rd_we(issueRdWe), .issue_rs1(issueRs1), .issue_rs2(issueRs2),
        .issue_fu(issueFu), .issue_lat(issueLat), .issue_ready(readyA),
        .flush_valid(flushValid), .flush_fu_mask(flushMask), .pnd_vec(pndA),
        .rs1_fu(rs1FuA), .rs2_fu(rs2FuA), .pending_count(countA)
    );

    scoreboard_param #(.ZERO_REG(0), .FORWARD(0)) dutB (
        .clk(clk), .reset(reset), .issue_valid(issueValid), .issue_rd(issueRd),
        .issue_rd_we(issueRdWe), .issue_rs1(issueRs1), .issue_rs2(issueRs2),
        .issue_fu(issueFu), .issue_lat(issueLat), .issue_ready(readyB),
        .flush_valid(flushValid), .flush_fu_mask(flushMask), .pnd_vec(pndB),
        .rs1_fu(rs1FuB), .rs2_fu(rs2FuB), .pending_count(countB)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: time limit reached, got no finish expected finish");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Model m=0 mirrors instance A (zero reg, forwarding), m=1 instance B.
    function automatic bit mPending(int m, int r);
        return wb[m][r] > cyc;
    endfunction

    function automatic bit mBusy(int m, int r);
        if (m == 0 && r == 0) return 1'b0;
        if (!mPending(m, r)) return 1'b0;
        if (m == 0 && (wb[m][r] - cyc) == 1) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit mReady(int m);
        if (flushValid) return 1'b0;
        if (mBusy(m, int'(issueRs1)) || mBusy(m, int'(issueRs2))) return 1'b0;
        if (issueRdWe && mBusy(m, int'(issueRd))) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [NR-1:0] mPndVec(int m);
        logic [NR-1:0] v;
        for (int r = 0; r < NR; r++) v[r] = mPending(m, r);
        return v;
    endfunction

    function automatic int mCount(int m);
        int n = 0;
        for (int r = 0; r < NR; r++) if (mPending(m, r)) n++;
        return n;
    endfunction

    function automatic void mReset();
        for (int m = 0; m < 2; m++)
            for (int r = 0; r < NR; r++) begin
                wb[m][r]  = 0;
                own[m][r] = 0;
            end
    endfunction

    function automatic bit mEdge(int m);
        bit acc;
        int lat;
        acc = issueValid && mReady(m);
        if (flushValid)
            for (int r = 0; r < NR; r++)
                if (mPending(m, r) && flushMask[own[m][r]]) wb[m][r] = 0;
        if (acc && issueRdWe && !(m == 0 && issueRd == 0)) begin
            lat = (issueLat == 0) ? 1 : int'(issueLat);
            wb[m][int'(issueRd)]  = cyc + 1 + lat;
            own[m][int'(issueRd)] = int'(issueFu);
        end
        return acc;
    endfunction

    task automatic checkDut(input int m, input string nm, input logic [NR-1:0] pnd,
                            input logic [AW:0] cnt, input logic rdy,
                            input logic [FW-1:0] f1, input logic [FW-1:0] f2);
        checkOutput({nm, " pnd_vec"}, 64'(pnd), 64'(mPndVec(m)));
        checkOutput({nm, " pending_count"}, 64'(cnt), 64'(mCount(m)));
        checkOutput({nm, " issue_ready"}, 64'(rdy), 64'(mReady(m)));
        if (mPending(m, int'(issueRs1)))
            checkOutput({nm, " rs1_fu"}, 64'(f1), 64'(own[m][int'(issueRs1)]));
        if (mPending(m, int'(issueRs2)))
            checkOutput({nm, " rs2_fu"}, 64'(f2), 64'(own[m][int'(issueRs2)]));
    endtask

    // One full cycle: drive at negedge, check mid-cycle, advance the model at posedge.
    task automatic applyStimulus(input bit v, input int rd, input bit we, input int rs1,
                                 input int rs2, input int fu, input int lat,
                                 input bit fl, input int mask, output bit rdyA);
        @(negedge clk);
        issueValid = v;
        issueRd    = AW'(rd);
        issueRdWe  = we;
        issueRs1   = AW'(rs1);
        issueRs2   = AW'(rs2);
        issueFu    = FW'(fu);
        issueLat   = LW'(lat);
        flushValid = fl;
        flushMask  = NF'(mask);
        #1;
        rdyA = readyA;
        checkDut(0, "A", pndA, countA, readyA, rs1FuA, rs2FuA);
        checkDut(1, "B", pndB, countB, readyB, rs1FuB, rs2FuB);
        @(posedge clk);
        void'(mEdge(0));
        void'(mEdge(1));
        cyc++;
    endtask

    task automatic idle(input int n, input int rs1);
        bit r;
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, rs1, 1, 0, 0, 0, 0, r);
    endtask

    function automatic int pickReg();
        if ($urandom_range(0, 9) < 8) return int'($urandom_range(0, 7));
        return int'($urandom_range(0, NR-1));
    endfunction

    initial begin
        bit r;
        bool_dummy: begin end
        mReset();
        #2;
        checkOutput("reset pnd_vec A", 64'(pndA), 64'(0));
        checkOutput("reset pending_count A", 64'(countA), 64'(0));
        checkOutput("reset issue_ready A", 64'(readyA), 64'(1));
        checkOutput("reset pnd_vec B", 64'(pndB), 64'(0));
        @(negedge clk);
        reset = 1'b1;

        // Latency: rd=5, fu=2, lat=3 stays pending for exactly three cycles.
        applyStimulus(1, 5, 1, 1, 2, 2, 3, 0, 0, r);
        for (int i = 0; i < 5; i++) begin
            #1;
            checkOutput("lat3 pnd_vec[5]", 64'(pndA[5]), 64'(i < 3));
            idle(1, 5);
        end

        // RAW: producer rd=7 lat=4, dependent on rs1=7 held until accepted.
        applyStimulus(1, 7, 1, 1, 2, 1, 4, 0, 0, r);
        r = 1'b0;
        for (int i = 0; i < 12 && !r; i++) applyStimulus(1, 8, 1, 7, 2, 0, 2, 0, 0, r);
        checkOutput("raw accepted within bound", 64'(r), 64'(1));
        idle(6, 0);

        // WAW: rd=9 lat=5, second write to rd=9 held until accepted.
        applyStimulus(1, 9, 1, 1, 2, 3, 5, 0, 0, r);
        r = 1'b0;
        for (int i = 0; i < 12 && !r; i++) applyStimulus(1, 9, 1, 1, 2, 0, 6, 0, 0, r);
        checkOutput("waw accepted within bound", 64'(r), 64'(1));
        #1;
        checkOutput("waw pnd_vec[9]", 64'(pndA[9]), 64'(1));
        idle(8, 9);

        // Register 0 is never pending on A, and rs1=0 never stalls there.
        applyStimulus(1, 0, 1, 1, 2, 1, 3, 0, 0, r);
        #1;
        checkOutput("zero pnd_vec[0]", 64'(pndA[0]), 64'(0));
        applyStimulus(1, 10, 1, 0, 0, 0, 2, 0, 0, r);
        checkOutput("zero rs1 ready", 64'(r), 64'(1));
        idle(6, 0);

        // Flush FU1 only: reg 3 clears, reg 4 stays, no issue in the flush cycle.
        applyStimulus(1, 3, 1, 1, 2, 1, 8, 0, 0, r);
        applyStimulus(1, 4, 1, 1, 2, 2, 8, 0, 0, r);
        applyStimulus(1, 10, 1, 1, 2, 0, 2, 1, 4'b0010, r);
        checkOutput("flush issue_ready", 64'(r), 64'(0));
        #1;
        checkOutput("flush pnd_vec[3]", 64'(pndA[3]), 64'(0));
        checkOutput("flush pnd_vec[4]", 64'(pndA[4]), 64'(1));
        idle(10, 0);

        // Asynchronous reset in the middle of five countdowns.
        for (int i = 11; i < 16; i++) applyStimulus(1, i, 1, 1, 2, i % NF, 12, 0, 0, r);
        idle(2, 11);
        #1;
        checkOutput("pre-reset pending_count", 64'(countA), 64'(5));
        @(negedge clk);
        issueValid = 1'b0;
        issueRdWe  = 1'b0;
        flushValid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        checkOutput("async reset pnd_vec A", 64'(pndA), 64'(0));
        checkOutput("async reset pending_count A", 64'(countA), 64'(0));
        checkOutput("async reset pnd_vec B", 64'(pndB), 64'(0));
        checkOutput("async reset pending_count B", 64'(countB), 64'(0));
        mReset();
        #1;
        reset = 1'b1;
        @(posedge clk);
        cyc++;

        // issue_lat=0 behaves as a one-cycle latency.
        applyStimulus(1, 6, 1, 1, 2, 1, 0, 0, 0, r);
        #1;
        checkOutput("lat0 pnd_vec[6] set", 64'(pndA[6]), 64'(1));
        idle(1, 6);
        #1;
        checkOutput("lat0 pnd_vec[6] cleared", 64'(pndA[6]), 64'(0));

        // Randomised traffic with hazards concentrated on low registers.
        for (int i = 0; i < 500; i++) begin
            applyStimulus($urandom_range(0, 3) != 0, pickReg(), $urandom_range(0, 4) != 0,
                          pickReg(), pickReg(), int'($urandom_range(0, NF-1)),
                          int'($urandom_range(0, 7)), $urandom_range(0, 11) == 0,
                          int'($urandom_range(0, 15)), r);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
